// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared widths, FSM states and term-table entry type for the polynomial sequencer
package poly_pkg;

  localparam int W_IN  = 8;
  localparam int W_OUT = 24;
  localparam int EXP_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TINIT,
    MUL,
    ACC,
    OUT2,
    DONE
  } state_t;

  typedef struct packed {
    logic [W_OUT-1:0] coef;
    logic [EXP_W-1:0] exp1;
    logic [EXP_W-1:0] exp2;
    logic [EXP_W-1:0] exp3;
  } term_t;

endpackage

// File: rtl/poly_term_sequencer_if.sv
// rtl/poly_term_sequencer_if.sv - operand and result handshake bundle of the polynomial sequencer
interface poly_term_sequencer_if;
  import poly_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [W_IN-1:0]    in1;
  logic [W_IN-1:0]    in2;
  logic [W_IN-1:0]    in3;
  logic               out_valid;
  logic               out_ready;
  logic [W_OUT-1:0]   out1;
  logic [2*W_IN-1:0]  out2;

  modport master (
    output in_valid, in1, in2, in3, out_ready,
    input  in_ready, out_valid, out1, out2
  );

  modport slave (
    input  in_valid, in1, in2, in3, out_ready,
    output in_ready, out_valid, out1, out2
  );

endinterface

// File: rtl/poly_mul_unit.sv
// rtl/poly_mul_unit.sv - combinational 24x8 multiplier returning the full 32-bit product
module poly_mul_unit
  import poly_pkg::*;
(
  input  logic [W_OUT-1:0]      a,
  input  logic [W_IN-1:0]       b,
  output logic [W_OUT+W_IN-1:0] p
);

  assign p = {{W_IN{1'b0}}, a} * {{W_OUT{1'b0}}, b};

endmodule

// File: rtl/poly_term_sequencer.sv
// rtl/poly_term_sequencer.sv - evaluates a sparse three-variable polynomial one term at a time on one shared multiplier
module poly_term_sequencer
  import poly_pkg::*;
#(
  parameter int NUM_TERMS = 24,
  parameter int ADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [W_OUT-1:0]     cfg_coef,
  input  logic [EXP_W-1:0]     cfg_exp1,
  input  logic [EXP_W-1:0]     cfg_exp2,
  input  logic [EXP_W-1:0]     cfg_exp3,
  input  logic                 cfg_len_we,
  input  logic [ADDR_W:0]      cfg_len,
  output logic                 busy,
  poly_term_sequencer_if.slave io
);

  localparam logic [ADDR_W:0] NT = (ADDR_W+1)'(NUM_TERMS);

  state_t state, state_nxt;

  term_t             table_q [NUM_TERMS];
  term_t             cur_term;
  logic [ADDR_W:0]   num_terms;
  logic [ADDR_W-1:0] t;
  logic [W_IN-1:0]   op1, op2, op3;
  logic [W_OUT-1:0]  acc, prod, out1_q;
  logic [2*W_IN-1:0] out2_q;
  logic [EXP_W-1:0]  e1, e2, e3;
  logic [EXP_W+1:0]  exp_left;
  logic              last_term, term_zero;

  logic [W_IN-1:0]        opnd;
  logic [W_OUT-1:0]       mul_a;
  logic [W_IN-1:0]        mul_b;
  logic [W_OUT+W_IN-1:0]  mul_p;
  logic                   unused_hi;

  assign cur_term  = table_q[t];
  assign last_term = ({1'b0, t} == num_terms - 1'b1);
  assign term_zero = (cur_term.exp1 == '0) && (cur_term.exp2 == '0) && (cur_term.exp3 == '0);
  assign exp_left  = {2'b00, e1} + {2'b00, e2} + {2'b00, e3};
  assign unused_hi = ^mul_p[W_OUT+W_IN-1:W_OUT];

  poly_mul_unit u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    opnd      = op3;
    if (e1 != '0)      opnd = op1;
    else if (e2 != '0) opnd = op2;
    mul_a = prod;
    mul_b = opnd;
    // OUT2 borrows the multiplier for the exact in1*in3 side product
    if (state == OUT2) begin
      mul_a = W_OUT'(op1);
      mul_b = op3;
    end
    case (state)
      IDLE:    if (io.in_valid) state_nxt = LOAD;
      LOAD:    state_nxt = (num_terms == '0) ? OUT2 : TINIT;
      TINIT:   state_nxt = term_zero ? ACC : MUL;
      MUL:     if (exp_left == (EXP_W+2)'(1)) state_nxt = ACC;
      ACC:     state_nxt = last_term ? OUT2 : TINIT;
      OUT2:    state_nxt = DONE;
      DONE:    if (io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Table contents survive reset; writes only land while idle
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && cfg_we && ({1'b0, cfg_addr} < NT))
      table_q[cfg_addr] <= '{coef: cfg_coef, exp1: cfg_exp1, exp2: cfg_exp2, exp3: cfg_exp3};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_terms <= '0;
      acc       <= '0;
      prod      <= '0;
      out1_q    <= '0;
      out2_q    <= '0;
      t         <= '0;
      e1        <= '0;
      e2        <= '0;
      e3        <= '0;
      op1       <= '0;
      op2       <= '0;
      op3       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_len_we) num_terms <= (cfg_len > NT) ? NT : cfg_len;
          if (io.in_valid) begin
            op1 <= io.in1;
            op2 <= io.in2;
            op3 <= io.in3;
            acc <= '0;
            t   <= '0;
          end
        end
        TINIT: begin
          prod <= cur_term.coef;
          e1   <= cur_term.exp1;
          e2   <= cur_term.exp2;
          e3   <= cur_term.exp3;
        end
        MUL: begin
          prod <= mul_p[W_OUT-1:0];
          if (e1 != '0)      e1 <= e1 - 1'b1;
          else if (e2 != '0) e2 <= e2 - 1'b1;
          else if (e3 != '0) e3 <= e3 - 1'b1;
        end
        ACC: begin
          acc <= acc + prod;
          if (!last_term) t <= t + 1'b1;
        end
        OUT2: begin
          out2_q <= mul_p[2*W_IN-1:0];
          out1_q <= acc;
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.out1      = out1_q;
  assign io.out2      = out2_q;
  assign busy         = (state != IDLE);

endmodule
